// File: rtl/data_memory_bank.sv
// Word-addressed data memory with byte-enable stores, a fixed-latency read pipeline,
// and a zero-fill sweep of the whole array after every reset before requests are accepted.
module data_memory_bank #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 10,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Load,
    input  logic                  Store,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [DATA_W/8-1:0]   byte_en,
    output logic                  ready,
    output logic [DATA_W-1:0]     read_data,
    output logic                  read_valid,
    output logic                  error
);

    localparam int NB = DATA_W / 8;

    typedef enum logic {S_INIT, S_IDLE} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic                 error_q, error_d;

    logic [DATA_W-1:0]    mem [DEPTH];

    logic                 in_range;
    logic                 illegal;
    logic                 load_acc;
    logic                 store_acc;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    lane_mask;
    logic [DATA_W-1:0]    rd_word;

    logic [DATA_W-1:0]       pipe_data_q [READ_LATENCY];
    logic [DATA_W-1:0]       pipe_data_d [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;

    assign ready      = (state_q == S_IDLE);
    assign error      = error_q;
    assign read_data  = pipe_data_q[READ_LATENCY-1];
    assign read_valid = pipe_vld_q[READ_LATENCY-1];

    // One extra bit on the compare so DEPTH == 2**ADDR_W never flags an address.
    assign in_range  = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
    assign illegal   = (Load && Store) || ((Load || Store) && !in_range);
    assign load_acc  = ready && !reset && Load && !Store && in_range;
    assign store_acc = ready && !reset && Store && !Load && in_range;
    assign rd_word   = mem[addr];

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NB; i++) begin
            lane_mask[8*i +: 8] = {8{byte_en[i]}};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = (rd_word & ~lane_mask) | (write_data & lane_mask);
        error_d   = ready && illegal;
        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_IDLE: begin
                mem_we = store_acc;
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Read pipeline: stage 0 captures the post-write array word, later stages shift.
    // Data stages only load when valid arrives so read_data holds between strobes.
    always_comb begin
        pipe_vld_d[0]  = load_acc;
        pipe_data_d[0] = load_acc ? rd_word : pipe_data_q[0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_data_d[i] = pipe_vld_q[i-1] ? pipe_data_q[i-1] : pipe_data_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_INIT;
            cnt_q      <= '0;
            error_q    <= 1'b0;
            pipe_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            error_q    <= error_d;
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data_q[i] <= pipe_data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_bank.sv
// Drives three memory instances (read latency 1, 2, 3) with shared stimulus and checks
// them against a behavioural model of the array, the clear sweep and the load latency.
module tb_data_memory_bank;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1000;
    localparam int NI     = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              Load, Store;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [1:0]        byte_en;

    logic              rdy  [NI];
    logic [DATA_W-1:0] rdat [NI];
    logic              rvld [NI];
    logic              err  [NI];

    always #5 clk = ~clk;

    data_memory_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .Load(Load), .Store(Store), .addr(addr),
        .write_data(write_data), .byte_en(byte_en), .ready(rdy[0]),
        .read_data(rdat[0]), .read_valid(rvld[0]), .error(err[0]));

    data_memory_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .Load(Load), .Store(Store), .addr(addr),
        .write_data(write_data), .byte_en(byte_en), .ready(rdy[1]),
        .read_data(rdat[1]), .read_valid(rvld[1]), .error(err[1]));

    data_memory_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .Load(Load), .Store(Store), .addr(addr),
        .write_data(write_data), .byte_en(byte_en), .ready(rdy[2]),
        .read_data(rdat[2]), .read_valid(rvld[2]), .error(err[2]));

    typedef struct {
        int unsigned       due;
        logic [DATA_W-1:0] data;
    } rd_t;

    logic [DATA_W-1:0] mem_m [DEPTH];
    rd_t               pend [NI][$];
    logic [DATA_W-1:0] m_last [NI];
    int unsigned       edge_n = 0;
    int                init_left = 0;
    logic              m_ready = 1'b0;
    logic              m_err = 1'b0;
    bit                started = 1'b0;
    bit                m_ok;
    rd_t               m_ent;

    int checks = 0;
    int errors = 0;

    // Reference: a sweep of DEPTH edges after reset, then Load^Store in range is accepted;
    // a load at edge E is due after edge E+latency-1.
    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            started   = 1'b1;
            init_left = DEPTH;
            m_ready   = 1'b0;
            m_err     = 1'b0;
            for (int k = 0; k < NI; k++) begin
                pend[k].delete();
                m_last[k] = '0;
            end
            for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
        end else if (started) begin
            m_err = 1'b0;
            if (!m_ready) begin
                init_left--;
                if (init_left == 0) m_ready = 1'b1;
            end else begin
                m_ok = (Load ^ Store) && (int'(addr) < DEPTH);
                if ((Load || Store) && !m_ok) m_err = 1'b1;
                if (m_ok && Store) begin
                    for (int b = 0; b < 2; b++)
                        if (byte_en[b]) mem_m[addr][8*b +: 8] = write_data[8*b +: 8];
                end
                if (m_ok && Load) begin
                    for (int k = 0; k < NI; k++) begin
                        m_ent.due  = edge_n + k;
                        m_ent.data = mem_m[addr];
                        pend[k].push_back(m_ent);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic exp_v;
        for (int k = 0; k < NI; k++) begin
            exp_v = 1'b0;
            if (pend[k].size() > 0 && pend[k][0].due == edge_n) begin
                exp_v     = 1'b1;
                m_last[k] = pend[k][0].data;
                void'(pend[k].pop_front());
            end
            chk($sformatf("ready_l%0d@%0d", k+1, edge_n), {15'b0, rdy[k]}, {15'b0, m_ready});
            chk($sformatf("error_l%0d@%0d", k+1, edge_n), {15'b0, err[k]}, {15'b0, m_err});
            chk($sformatf("valid_l%0d@%0d", k+1, edge_n), {15'b0, rvld[k]}, {15'b0, exp_v});
            chk($sformatf("data_l%0d@%0d", k+1, edge_n), rdat[k], m_last[k]);
        end
    endtask

    task automatic cyc(input logic l, input logic s, input int a, input logic [15:0] d, input logic [1:0] be);
        Load       = l;
        Store      = s;
        addr       = ADDR_W'(a);
        write_data = d;
        byte_en    = be;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 16'h0, 2'b00);
    endtask

    initial begin
        int r, a;
        reset = 1'b1;
        Load = 1'b0; Store = 1'b0; addr = '0; write_data = '0; byte_en = '0;
        @(posedge clk);
        @(negedge clk);
        idle(3);

        // T1: release reset; junk requests during the sweep must be ignored.
        reset = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i % 97 == 3) cyc(1'b0, 1'b1, i % 16, 16'hFFFF, 2'b11);
            else if (i % 97 == 5) cyc(1'b1, 1'b1, 7, 16'h0, 2'b00);
            else cyc(1'b0, 1'b0, 0, 16'h0, 2'b00);
        end
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, i, 16'h0, 2'b00);
        idle(4);

        // T2: byte-lane merges.
        cyc(1'b0, 1'b1, 5, 16'hBEEF, 2'b01);
        cyc(1'b1, 1'b0, 5, 16'h0, 2'b00);
        chk("t2_lane0", rdat[0], 16'h00EF);
        cyc(1'b0, 1'b1, 5, 16'h1234, 2'b10);
        cyc(1'b1, 1'b0, 5, 16'h0, 2'b00);
        chk("t2_lane1", rdat[0], 16'h12EF);
        idle(4);

        // T3: back-to-back loads through every latency.
        cyc(1'b0, 1'b1, 1, 16'h1111, 2'b11);
        cyc(1'b0, 1'b1, 2, 16'h2222, 2'b11);
        cyc(1'b0, 1'b1, 3, 16'h3333, 2'b11);
        cyc(1'b1, 1'b0, 1, 16'h0, 2'b00);
        cyc(1'b1, 1'b0, 2, 16'h0, 2'b00);
        cyc(1'b1, 1'b0, 3, 16'h0, 2'b00);
        chk("t3_first_l3", rdat[2], 16'h1111);
        idle(4);
        chk("t3_hold_l3", rdat[2], 16'h3333);

        // T4: illegal requests leave memory untouched.
        cyc(1'b0, 1'b1, 7, 16'h7777, 2'b11);
        cyc(1'b1, 1'b1, 7, 16'hDEAD, 2'b11);
        chk("t4_err_both", {15'b0, err[0]}, 16'h0001);
        cyc(1'b1, 1'b0, DEPTH, 16'h0, 2'b00);
        chk("t4_err_range", {15'b0, err[0]}, 16'h0001);
        cyc(1'b0, 1'b1, 1023, 16'hDEAD, 2'b11);
        cyc(1'b1, 1'b0, 7, 16'h0, 2'b00);
        chk("t4_mem7", rdat[0], 16'h7777);
        idle(4);

        // T6 and empty byte-enable store.
        cyc(1'b0, 1'b1, 9, 16'hA5A5, 2'b11);
        cyc(1'b1, 1'b0, 9, 16'h0, 2'b00);
        chk("t6_raw", rdat[0], 16'hA5A5);
        cyc(1'b0, 1'b1, 9, 16'hFFFF, 2'b00);
        cyc(1'b1, 1'b0, 9, 16'h0, 2'b00);
        idle(4);

        // Randomised mix near both ends of the address space.
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 7);
            a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(DEPTH - 5, 1023);
            cyc(r inside {[0:2], 6}, r inside {[3:6]}, a, 16'($urandom), 2'($urandom));
        end
        idle(4);

        // T5: reset one cycle after a load drops it and re-clears the array.
        cyc(1'b0, 1'b1, 5, 16'hC0DE, 2'b11);
        cyc(1'b1, 1'b0, 5, 16'h0, 2'b00);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(DEPTH + 2);
        cyc(1'b1, 1'b0, 5, 16'h0, 2'b00);
        cyc(1'b1, 1'b0, 9, 16'h0, 2'b00);
        chk("t5_cleared", rdat[0], 16'h0000);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
